// File: rtl/sr_dmem.sv
// sr_dmem: byte-addressed little-endian data memory with wait states and access error detection.
// Single request in flight; responses are a one-cycle pulse after WAIT_STATES+1 busy cycles.
module sr_dmem #(
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int WORDS = DEPTH / 4;
    localparam int IW    = WORDS > 1 ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q, sign_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic [31:0] mem [WORDS];

    logic [IW-1:0] idx;
    logic [4:0]    sh;
    logic [3:0]    be;
    logic [31:0]   wd, rword, rsh, ld;
    logic          err, commit;

    assign idx    = addr_q[IW+1:2];
    assign sh     = {addr_q[1:0], 3'b000};
    assign be     = size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
                    size_q == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;
    assign wd     = wdata_q << sh;
    assign rword  = mem[idx];
    assign rsh    = rword >> sh;
    assign ld     = size_q == 2'b00 ? {{24{sign_q & rsh[7]}}, rsh[7:0]} :
                    size_q == 2'b01 ? {{16{sign_q & rsh[15]}}, rsh[15:0]} : rsh;
    // Full 32-bit range compare so high addresses never alias into the array.
    assign err    = (size_q == 2'b11) | (size_q == 2'b01 & addr_q[0]) |
                    (size_q == 2'b10 & addr_q[1:0] != 2'b00) | (addr_q >= 32'(DEPTH));
    assign commit = state_q == BUSY && cnt_q == 4'd0;

    // Gated by rst so an aborted store never reaches the array.
    always_ff @(posedge clk) begin
        if (!rst && commit && we_q && !err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            sign_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid && req_ready) begin
                    we_q      <= req_we;
                    addr_q    <= req_addr;
                    wdata_q   <= req_wdata;
                    size_q    <= req_size;
                    sign_q    <= req_sign;
                    cnt_q     <= 4'(WAIT_STATES);
                    req_ready <= 1'b0;
                    state_q   <= BUSY;
                end
                BUSY: if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                    rsp_rdata <= (err || we_q) ? 32'd0 : ld;
                    state_q   <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_dmem.sv
// tb_sr_dmem: directed checks of sr_dmem with WAIT_STATES=0 (u0) and WAIT_STATES=3 (u1).
module tb_sr_dmem;
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

    logic        clk = 1'b0, rst = 1'b1;
    logic [1:0]  vld = 2'b00;
    logic        we = 1'b0, sign = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  size = 2'b00;
    logic [1:0]  rdy, rv, er;
    logic [31:0] rd0, rd1;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    sr_dmem #(.DEPTH(512), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_size(size), .req_sign(sign),
        .rsp_valid(rv[0]), .rsp_rdata(rd0), .rsp_err(er[0]));

    sr_dmem #(.DEPTH(512), .WAIT_STATES(3)) u1 (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_size(size), .req_sign(sign),
        .rsp_valid(rv[1]), .rsp_rdata(rd1), .rsp_err(er[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic op(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic sg, input logic [31:0] exp_rd,
                      input logic exp_err, input string tag);
        int lat;
        logic [31:0] got_rd;
        logic got_err;
        @(negedge clk);
        we = w; addr = a; wdata = wd; size = sz; sign = sg;
        vld[d] = 1'b1;
        @(posedge clk);
        #1 vld[d] = 1'b0;
        lat = -1; got_rd = 'x; got_err = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rv[d]) begin
                lat = k; got_rd = d ? rd1 : rd0; got_err = er[d];
                break;
            end
        end
        chk({tag, " lat"}, lat, d ? 5 : 2);
        chk({tag, " rdata"}, got_rd, exp_rd);
        chk({tag, " err"}, {31'd0, got_err}, {31'd0, exp_err});
    endtask

    int pulses;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst ready", {30'd0, rdy}, 32'd3);
        chk("rst valid", {30'd0, rv}, 32'd0);
        chk("rst err", {30'd0, er}, 32'd0);
        chk("rst rdata0", rd0, 32'd0);
        rst = 1'b0;

        op(0, 1, 32'h10, 32'hDEADBEEF, W, 0, 32'h0, 0, "st w 10");
        op(0, 0, 32'h10, 32'h0, W, 0, 32'hDEADBEEF, 0, "ld w 10");

        op(0, 1, 32'h11, 32'h12345680, B, 0, 32'h0, 0, "st b 11");
        op(0, 0, 32'h11, 32'h0, B, 1, 32'hFFFFFF80, 0, "ld bs 11");
        op(0, 0, 32'h11, 32'h0, B, 0, 32'h00000080, 0, "ld bu 11");
        op(0, 0, 32'h10, 32'h0, W, 1, 32'hDEAD80EF, 0, "ld w 10b");
        op(0, 0, 32'h13, 32'h0, B, 1, 32'hFFFFFFDE, 0, "ld bs 13");
        op(0, 0, 32'h12, 32'h0, H, 0, 32'h0000DEAD, 0, "ld hu 12");

        op(0, 1, 32'h20, 32'h11223344, W, 0, 32'h0, 0, "st w 20");
        op(0, 1, 32'h22, 32'hABCD8001, H, 0, 32'h0, 0, "st h 22");
        op(0, 0, 32'h22, 32'h0, H, 1, 32'hFFFF8001, 0, "ld hs 22");
        op(0, 0, 32'h20, 32'h0, H, 1, 32'h00003344, 0, "ld hs 20");
        op(0, 0, 32'h21, 32'h0, H, 1, 32'h0, 1, "ld h 21");
        op(0, 1, 32'h21, 32'hFFFFFFFF, H, 0, 32'h0, 1, "st h 21");
        op(0, 0, 32'h20, 32'h0, W, 0, 32'h80013344, 0, "ld w 20");

        op(0, 1, 32'h13, 32'h55555555, W, 0, 32'h0, 1, "st w 13");
        op(0, 1, 32'h200, 32'h55555555, B, 0, 32'h0, 1, "st b 200");
        op(0, 1, 32'h10, 32'h55555555, X, 0, 32'h0, 1, "st x 10");
        op(0, 1, 32'h80000010, 32'h55555555, W, 0, 32'h0, 1, "st w wrap");
        op(0, 0, 32'h200, 32'h0, W, 0, 32'h0, 1, "ld w 200");
        op(0, 0, 32'h10, 32'h0, W, 0, 32'hDEAD80EF, 0, "ld w 10c");
        op(0, 1, 32'h1FC, 32'hCAFEF00D, W, 0, 32'h0, 0, "st w 1fc");
        op(0, 0, 32'h1FF, 32'h0, B, 0, 32'h000000CA, 0, "ld b 1ff");

        // WAIT_STATES=3 timing with req_valid held high across the response
        @(negedge clk);
        we = 1'b0; addr = 32'h40; size = W; sign = 1'b0;
        vld[1] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("ws3 ready c%0d", k), {31'd0, rdy[1]}, {31'd0, k == 6});
            chk($sformatf("ws3 valid c%0d", k), {31'd0, rv[1]}, {31'd0, k == 5});
        end
        @(negedge clk);
        chk("ws3 reaccept", {31'd0, rdy[1]}, 32'd0);
        vld[1] = 1'b0;
        repeat (6) @(negedge clk);
        chk("ws3 idle", {31'd0, rdy[1]}, 32'd1);

        // Reset in BUSY aborts a pending store
        op(1, 1, 32'h40, 32'h0, W, 0, 32'h0, 0, "ws3 st 40 zero");
        @(negedge clk);
        we = 1'b1; addr = 32'h40; wdata = 32'h12345678; size = W;
        vld[1] = 1'b1;
        @(posedge clk);
        #1 vld[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort busy", {31'd0, rdy[1]}, 32'd0);
        rst = 1'b1;
        #1;
        chk("abort ready", {31'd0, rdy[1]}, 32'd1);
        chk("abort valid", {31'd0, rv[1]}, 32'd0);
        chk("abort rdata", rd1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (rv[1]) pulses++;
        end
        chk("abort no rsp", pulses, 0);
        op(1, 0, 32'h40, 32'h0, W, 0, 32'h0, 0, "ws3 ld 40");
        op(0, 0, 32'h10, 32'h0, W, 0, 32'hDEAD80EF, 0, "ld w 10 post rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sr_dmem.md
Name: sr_dmem

Overview:
- Next-generation data memory for the schoolRISCV core.
- Byte-addressed, little-endian, word-organised storage with per-byte write enables.
- Request/response handshake with a parametrised number of wait states, so the core can be exercised against slow memory.
- Detects misaligned, illegal-size and out-of-range accesses and reports them as errors instead of silently corrupting memory.

Parameters:
- DEPTH, 512, memory size in bytes; must be a multiple of 4 and at least 4.
- WAIT_STATES, 0, extra cycles inserted between request accept and response; range 0..15.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the value is in the low bits for byte and half stores.
- req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_sign  input  1  load sign-extends when 1, zero-extends when 0.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result, extended to 32 bits.
- rsp_err  output  1  access rejected; valid only while rsp_valid = 1.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, wait counter=0. Memory contents are not reset.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid & req_ready) latches we, addr, wdata, size and sign, loads the counter with WAIT_STATES, and moves to BUSY.
- BUSY:
  - req_ready=0.
  - When the counter is not 0, decrement it each cycle.
  - When the counter is 0, the next edge performs the access, drives rsp_valid=1, and moves to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, req_ready=0.
  - The next edge clears rsp_valid, clears rsp_rdata and rsp_err, and returns to IDLE.
- Latency:
  - rsp_valid is high in cycle WAIT_STATES+2, counting the accept edge as edge 0.
  - Back-to-back throughput is one access per WAIT_STATES+3 cycles.
  - Inputs are ignored outside the accept cycle.
- Error check, evaluated on the latched request:
  - size=11 is an error.
  - half with addr[0]≠0 is an error.
  - word with addr[1:0]≠0 is an error.
  - addr ≥ DEPTH (full 32-bit compare, no wrap-around) is an error.
- On error: rsp_err=1, rsp_rdata=0, memory unchanged.
- Store:
  - Byte enables are derived from size and addr[1:0]; only the enabled bytes change.
  - Each lane is taken from the low bits of wdata, shifted to its position.
  - The write commits on the edge that raises rsp_valid.
  - rsp_rdata=0, rsp_err=0.
- Load:
  - Data is read from the word at addr[..:2] and shifted down by the byte offset.
  - Byte and half results are extended per the latched sign: bit 7 or bit 15 replicated when sign=1, zero-filled otherwise.
  - Word loads ignore sign.
  - Data reflects every store whose response has already completed.
- Reset mid-operation (rst asserted in BUSY or RESP):
  - Immediately aborts and returns to the reset values.
  - A store that has not reached its commit edge must not modify memory.
  - No response is produced for the aborted request.
- req_valid held high through RESP is treated as a new request only once back in IDLE; there is no double-accept.

Test Plan:
1. WAIT_STATES=0: store word 0xDEADBEEF @0x10, then load word @0x10 → each rsp_valid arrives 2 cycles after accept; load rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Byte lanes: store byte 0x80 @0x11, then load byte signed @0x11 → 0xFFFFFF80; load byte unsigned @0x11 → 0x00000080; load word @0x10 → 0xDEAD80EF.
3. Half: store half 0x8001 @0x22, then load half signed @0x22 → 0xFFFF8001. Load half @0x21 → rsp_err=1, rsp_rdata=0, and the word @0x20 is unchanged.
4. Errors: word store @0x13, store @DEPTH (0x200), and size=11 → each gives rsp_err=1; a following load @0x10 still returns the prior contents.
5. WAIT_STATES=3: load accepted at edge 0 → req_ready=0 in cycles 1–5, rsp_valid high only in cycle 5, req_ready=1 in cycle 6; req_valid held high continuously → second accept at edge 6.
6. WAIT_STATES=3: store 0x12345678 @0x40 over old 0x0, with rst pulsed during BUSY → outputs return to reset values, no rsp_valid; a subsequent load @0x40 → 0x00000000.
